// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the 5-stage RV32I pipeline: decodes the ID opcode, shadows
// the EX/MEM/WB register usage and derives stalls, flushes, freezes and forwarding selects.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic [2:0]       imm_sel,
  output logic             illegal,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] ImmI    = 3'b000;
  localparam logic [2:0] ImmS    = 3'b001;
  localparam logic [2:0] ImmB    = 3'b010;
  localparam logic [2:0] ImmU    = 3'b011;
  localparam logic [2:0] ImmJ    = 3'b100;
  localparam logic [2:0] ImmNone = 3'b101;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdMem = 2'b10;
  localparam logic [1:0] FwdWb  = 2'b01;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ModeRun, ModeStall, ModeRedirect, ModeFreeze} mode_e;

  // Decoded ID attributes
  logic id_regwrite, id_is_load, id_uses_rs1, id_uses_rs2;
  logic load_use;
  mode_e mode;

  // Shadow pipeline state
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_is_load_q, ex_is_load_d;
  logic [4:0] ex_rs1_q, ex_rs1_d;
  logic [4:0] ex_rs2_q, ex_rs2_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_regwrite_q, mem_regwrite_d;
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic       wb_regwrite_q, wb_regwrite_d;

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Opcode decode: immediate format, legality and register-usage attributes
  always_comb begin
    imm_sel     = ImmNone;
    illegal     = 1'b0;
    id_regwrite = 1'b0;
    id_is_load  = 1'b0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    case (id_opcode)
      OpR: begin
        imm_sel     = ImmNone;
        id_regwrite = 1'b1;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
      end
      OpIAlu, OpJalr: begin
        imm_sel     = ImmI;
        id_regwrite = 1'b1;
        id_uses_rs1 = 1'b1;
      end
      OpLoad: begin
        imm_sel     = ImmI;
        id_regwrite = 1'b1;
        id_is_load  = 1'b1;
        id_uses_rs1 = 1'b1;
      end
      OpStore: begin
        imm_sel     = ImmS;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
      end
      OpBr: begin
        imm_sel     = ImmB;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
      end
      OpLui, OpAuipc: begin
        imm_sel     = ImmU;
        id_regwrite = 1'b1;
      end
      OpJal: begin
        imm_sel     = ImmJ;
        id_regwrite = 1'b1;
      end
      default: begin
        imm_sel = ImmNone;
        illegal = id_valid;
      end
    endcase
  end

  // Load-use detection and per-cycle mode selection, highest priority first
  always_comb begin
    load_use = id_valid & ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
               ((id_uses_rs1 & (ex_rd_q == id_rs1)) | (id_uses_rs2 & (ex_rd_q == id_rs2)));
    if (mem_busy) begin
      mode = ModeFreeze;
    end else if (ex_branch_taken) begin
      mode = ModeRedirect;
    end else if (load_use) begin
      mode = ModeStall;
    end else begin
      mode = ModeRun;
    end
  end

  // Pipeline enables and flushes for the current mode
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (mode)
      ModeFreeze: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      ModeRedirect: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ModeStall: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      ModeRun: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    endcase
  end

  // Shadow next-state: freeze holds, bubbles clear EX, run advances ID into EX
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_is_load_d   = ex_is_load_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_regwrite_d  = wb_regwrite_q;
    if (mode != ModeFreeze) begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      wb_valid_d     = mem_valid_q;
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      if (mode == ModeRun) begin
        ex_valid_d    = id_valid;
        ex_rd_d       = id_rd;
        ex_regwrite_d = id_regwrite;
        ex_is_load_d  = id_is_load;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
      end else begin
        // Bubble fields are zeroed so a stale operand never selects a forward
        ex_valid_d    = 1'b0;
        ex_rd_d       = 5'd0;
        ex_regwrite_d = 1'b0;
        ex_is_load_d  = 1'b0;
        ex_rs1_d      = 5'd0;
        ex_rs2_d      = 5'd0;
      end
    end
  end

  // Saturating count of bubbles injected into ID/EX
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (idex_flush && !mem_busy && (bubble_cnt_q != CntMax)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_rs1_q       <= 5'd0;
      ex_rs2_q       <= 5'd0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  // EX operand forwarding; MEM result is younger so it wins over WB
  always_comb begin
    logic mem_fwd_ok, wb_fwd_ok;
    mem_fwd_ok = mem_valid_q & mem_regwrite_q & (mem_rd_q != 5'd0);
    wb_fwd_ok  = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0);
    fwd_a = FwdRf;
    fwd_b = FwdRf;
    if (mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
      fwd_a = FwdMem;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
      fwd_a = FwdWb;
    end
    if (mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
      fwd_b = FwdMem;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
      fwd_b = FwdWb;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding, redirect priority, freeze, illegal
// opcodes, counter saturation and asynchronous reset during a stall.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpBad  = 7'b1111111;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic [2:0]       imm_sel;
  logic             illegal;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .imm_sel         (imm_sel),
    .illegal         (illegal),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .bubble_cnt      (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of ID/EX inputs on the falling edge; checks follow before the next rise
  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic br,
                       input logic busy);
    @(negedge clk);
    id_valid        = v;
    id_opcode       = op;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_rd           = rd;
    ex_branch_taken = br;
    mem_busy        = busy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, OpR, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    id_valid        = 1'b0;
    id_opcode       = OpBr;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_rd           = 5'd0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    #3;
    check_eq("rst_pc_write", pc_write, 1);
    check_eq("rst_ifid_write", ifid_write, 1);
    check_eq("rst_ifid_flush", ifid_flush, 0);
    check_eq("rst_idex_flush", idex_flush, 0);
    check_eq("rst_fwd_a", fwd_a, 0);
    check_eq("rst_fwd_b", fwd_b, 0);
    check_eq("rst_bubble_cnt", bubble_cnt, 0);
    check_eq("rst_imm_sel_b", imm_sel, 3'b010);
    check_eq("rst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x7
    drive(1'b1, OpLoad, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    check_eq("lw_no_stall", pc_write, 1);
    drive(1'b1, OpR, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    check_eq("lu_pc_write", pc_write, 0);
    check_eq("lu_ifid_write", ifid_write, 0);
    check_eq("lu_idex_flush", idex_flush, 1);
    check_eq("lu_ifid_flush", ifid_flush, 0);
    drive(1'b1, OpR, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    check_eq("lu_after_pc_write", pc_write, 1);
    check_eq("lu_after_idex_flush", idex_flush, 0);
    check_eq("lu_bubble_cnt", bubble_cnt, 1);
    idle();
    check_eq("lu_fwd_a_wb", fwd_a, 2'b01);
    check_eq("lu_fwd_b_rf", fwd_b, 2'b00);

    // add x1 ; sub x2,x1,x1 ; R x0,x1,x2 ; R x3,x0,x0
    drive(1'b1, OpR, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0);
    drive(1'b1, OpR, 5'd1, 5'd1, 5'd2, 1'b0, 1'b0);
    check_eq("alu_no_stall", pc_write, 1);
    drive(1'b1, OpR, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    check_eq("b2b_fwd_a_mem", fwd_a, 2'b10);
    check_eq("b2b_fwd_b_mem", fwd_b, 2'b10);
    drive(1'b1, OpR, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    check_eq("dist2_fwd_a_wb", fwd_a, 2'b01);
    check_eq("dist2_fwd_b_mem", fwd_b, 2'b10);
    idle();
    check_eq("x0_fwd_a", fwd_a, 2'b00);
    check_eq("x0_fwd_b", fwd_b, 2'b00);

    // Redirect in the same cycle as a load-use
    drive(1'b1, OpLoad, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    drive(1'b1, OpR, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
    check_eq("br_ifid_flush", ifid_flush, 1);
    check_eq("br_idex_flush", idex_flush, 1);
    check_eq("br_pc_write", pc_write, 1);
    check_eq("br_ifid_write", ifid_write, 1);
    drive(1'b1, OpR, 5'd8, 5'd0, 5'd9, 1'b0, 1'b0);
    check_eq("br_next_pc_write", pc_write, 1);
    check_eq("br_next_idex_flush", idex_flush, 0);
    check_eq("br_bubble_cnt", bubble_cnt, 2);

    // Freeze over a pending load-use, with a taken branch that must be ignored
    drive(1'b1, OpLoad, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0);
    check_eq("wb_fwd_after_br", fwd_a, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OpR, 5'd10, 5'd0, 5'd11, (i == 1), 1'b1);
      check_eq("frz_pc_write", pc_write, 0);
      check_eq("frz_ifid_write", ifid_write, 0);
      check_eq("frz_ifid_flush", ifid_flush, 0);
      check_eq("frz_idex_flush", idex_flush, 0);
    end
    check_eq("frz_bubble_cnt", bubble_cnt, 2);
    drive(1'b1, OpR, 5'd10, 5'd0, 5'd11, 1'b0, 1'b0);
    check_eq("frz_stall_pc_write", pc_write, 0);
    check_eq("frz_stall_idex_flush", idex_flush, 1);
    drive(1'b1, OpR, 5'd10, 5'd0, 5'd11, 1'b0, 1'b0);
    check_eq("frz_once_pc_write", pc_write, 1);
    check_eq("frz_once_idex_flush", idex_flush, 0);
    check_eq("frz_once_bubble_cnt", bubble_cnt, 3);
    idle();
    check_eq("frz_fwd_a_wb", fwd_a, 2'b01);

    // Illegal opcode after a load to the same registers: no hazard
    drive(1'b1, OpLoad, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0);
    drive(1'b1, OpBad, 5'd12, 5'd12, 5'd1, 1'b0, 1'b0);
    check_eq("ill_illegal", illegal, 1);
    check_eq("ill_imm_sel", imm_sel, 3'b101);
    check_eq("ill_pc_write", pc_write, 1);
    check_eq("ill_idex_flush", idex_flush, 0);
    drive(1'b0, OpBad, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("ill_invalid", illegal, 0);

    // 14 more redirects take the count from 3 to 17, saturating at 15
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, OpR, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      if (i == 11) check_eq("sat_cnt_14", bubble_cnt, 14);
    end
    idle();
    check_eq("sat_cnt_15", bubble_cnt, 15);

    // Asynchronous reset in the middle of a load-use stall
    drive(1'b1, OpLoad, 5'd0, 5'd0, 5'd13, 1'b0, 1'b0);
    drive(1'b1, OpR, 5'd13, 5'd0, 5'd14, 1'b0, 1'b0);
    check_eq("mid_stall_idex_flush", idex_flush, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pc_write", pc_write, 1);
    check_eq("arst_ifid_write", ifid_write, 1);
    check_eq("arst_idex_flush", idex_flush, 0);
    check_eq("arst_bubble_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, OpR, 5'd13, 5'd0, 5'd14, 1'b0, 1'b0);
    check_eq("arst_no_pending_stall", pc_write, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
